// File: rtl/snd_req_queue.sv
// Sound-request front end: FIFO of main-CPU sound numbers offered one at a time
// on a command latch with an NMI handshake, plus a programmable periodic IRQ.
module snd_req_queue #(
  parameter int CMD_W       = 8,
  parameter int FIFO_AW     = 2,
  parameter int TICK_PERIOD = 16667
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [CMD_W-1:0]   sndno,
  input  logic               sndstart,
  input  logic               com_rd,
  output logic [CMD_W-1:0]   comlatch,
  output logic               cpu_nmi,
  input  logic               cpu_nmia,
  output logic               cpu_irq,
  input  logic               cpu_irqa,
  input  logic               tick_en,
  output logic [FIFO_AW:0]   fifo_cnt,
  output logic               cmd_ovf,
  output logic               irq_ovr,
  input  logic               ovf_clr
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNT_W = $clog2(TICK_PERIOD);
  localparam logic [FIFO_AW:0] C_FULL      = DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW:0] C_CNT_ONE   = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0] C_CNT_ZERO  = (FIFO_AW+1)'(0);
  localparam logic [FIFO_AW-1:0] C_PTR_ONE = FIFO_AW'(1);
  localparam logic [CNT_W-1:0] C_TICK_LAST = CNT_W'(TICK_PERIOD - 1);
  localparam logic [CNT_W-1:0] C_T_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_T_ZERO    = CNT_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_prev;
  logic [CMD_W-1:0]     r_mem [DEPTH];
  logic [FIFO_AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]     r_cnt;
  logic [CMD_W-1:0]     r_latch, w_latch_nxt;
  logic                 r_nmi, w_nmi_nxt;
  logic [CNT_W-1:0]     r_tcnt;
  logic                 r_irq, r_ovr, r_ovf;
  logic                 w_push, w_pop, w_full, w_accept, w_drop, w_tick;

  assign w_push   = sndstart & ~r_prev;
  assign w_full   = (r_cnt == C_FULL);
  assign w_pop    = (r_state == ST_IDLE) && (r_cnt != C_CNT_ZERO);
  // A pop frees a slot on the same edge, so a full FIFO still accepts then.
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;
  assign w_tick   = tick_en && (r_tcnt == C_TICK_LAST);

  // Request edge detect, FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      r_prev <= sndstart;
      if (w_accept) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + C_CNT_ONE;
        2'b01:   r_cnt <= r_cnt - C_CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // FIFO storage, no reset needed since occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= sndno;
  end

  // NMI handshake next-state and latch/NMI next values
  always_comb begin
    w_state_nxt = r_state;
    w_latch_nxt = r_latch;
    w_nmi_nxt   = r_nmi;
    case (r_state)
      ST_IDLE: begin
        if (w_pop) begin
          w_latch_nxt = r_mem[r_rd_ptr];
          w_nmi_nxt   = 1'b1;
          w_state_nxt = ST_PEND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (cpu_nmia) begin
          w_nmi_nxt   = 1'b0;
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_PEND;
        end
      end
      ST_WAIT: begin
        if (com_rd) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_nmi_nxt   = 1'b0;
      end
    endcase
  end

  // NMI handshake state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_latch <= '0;
      r_nmi   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_latch <= w_latch_nxt;
      r_nmi   <= w_nmi_nxt;
    end
  end

  // Periodic IRQ timer; a tick beats a simultaneous acknowledge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tcnt <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (!tick_en)    r_tcnt <= C_T_ZERO;
      else if (w_tick) r_tcnt <= C_T_ZERO;
      else             r_tcnt <= r_tcnt + C_T_ONE;
      if (w_tick)        r_irq <= 1'b1;
      else if (cpu_irqa) r_irq <= 1'b0;
      else               r_irq <= r_irq;
    end
  end

  // Sticky error flags; setting wins over a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
      else              r_ovf <= r_ovf;
      if (w_tick && r_irq) r_ovr <= 1'b1;
      else if (ovf_clr)    r_ovr <= 1'b0;
      else                 r_ovr <= r_ovr;
    end
  end

  assign comlatch = r_latch;
  assign cpu_nmi  = r_nmi;
  assign cpu_irq  = r_irq;
  assign fifo_cnt = r_cnt;
  assign cmd_ovf  = r_ovf;
  assign irq_ovr  = r_ovr;

endmodule

// File: tb/tb_snd_req_queue.sv
// Directed bench for snd_req_queue: queue-based reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_snd_req_queue;
  localparam int P     = 10;
  localparam int DEPTH = 4;
  localparam int IDLE = 0, OFFERED = 1, READING = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] sndno;
  logic       sndstart, com_rd, cpu_nmia, cpu_irqa, tick_en, ovf_clr;
  logic [7:0] comlatch;
  logic       cpu_nmi, cpu_irq, cmd_ovf, irq_ovr;
  logic [2:0] fifo_cnt;

  always #5 clk = ~clk;

  snd_req_queue #(.CMD_W(8), .FIFO_AW(2), .TICK_PERIOD(P)) dut (
    .clk(clk), .reset_n(reset_n), .sndno(sndno), .sndstart(sndstart),
    .com_rd(com_rd), .comlatch(comlatch), .cpu_nmi(cpu_nmi), .cpu_nmia(cpu_nmia),
    .cpu_irq(cpu_irq), .cpu_irqa(cpu_irqa), .tick_en(tick_en), .fifo_cnt(fifo_cnt),
    .cmd_ovf(cmd_ovf), .irq_ovr(irq_ovr), .ovf_clr(ovf_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending commands as a queue, handshake phase, timer count
  logic [7:0] m_q [$];
  int         m_phase;
  logic [7:0] m_latch;
  logic       m_nmi, m_irq, m_ovr, m_ovf, m_prev;
  int         m_tcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_phase = IDLE;
    m_latch = 8'h00;
    m_nmi = 1'b0; m_irq = 1'b0; m_ovr = 1'b0; m_ovf = 1'b0; m_prev = 1'b0;
    m_tcnt = 0;
  endtask

  task automatic model_step();
    logic push, pop, room, tick;
    if (!reset_n) begin
      model_reset();
      return;
    end
    push   = sndstart && !m_prev;
    m_prev = sndstart;
    pop    = (m_phase == IDLE) && (m_q.size() > 0);
    room   = (m_q.size() < DEPTH) || pop;
    tick   = tick_en && (m_tcnt == P - 1);
    if (ovf_clr) begin
      m_ovf = 1'b0;
      m_ovr = 1'b0;
    end
    if (pop) begin
      m_latch = m_q.pop_front();
      m_nmi   = 1'b1;
      m_phase = OFFERED;
    end else if (m_phase == OFFERED && cpu_nmia) begin
      m_nmi   = 1'b0;
      m_phase = READING;
    end else if (m_phase == READING && com_rd) begin
      m_phase = IDLE;
    end
    if (push) begin
      if (room) m_q.push_back(sndno);
      else      m_ovf = 1'b1;
    end
    if (tick && m_irq) m_ovr = 1'b1;
    if (tick)          m_irq = 1'b1;
    else if (cpu_irqa) m_irq = 1'b0;
    if (!tick_en || tick) m_tcnt = 0;
    else                  m_tcnt = m_tcnt + 1;
  endtask

  task automatic compare();
    chk("comlatch", comlatch, m_latch);
    chk("cpu_nmi",  cpu_nmi,  m_nmi);
    chk("cpu_irq",  cpu_irq,  m_irq);
    chk("irq_ovr",  irq_ovr,  m_ovr);
    chk("cmd_ovf",  cmd_ovf,  m_ovf);
    chk("fifo_cnt", fifo_cnt, m_q.size());
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic push(input logic [7:0] d);
    sndno = d; sndstart = 1'b1;
    cycle();
    sndstart = 1'b0;
    cycle();
  endtask

  task automatic serve(input logic [7:0] exp);
    chk("serve_latch", comlatch, exp);
    chk("serve_nmi_on", cpu_nmi, 1);
    cpu_nmia = 1'b1; cycle(); cpu_nmia = 1'b0;
    chk("serve_nmi_off", cpu_nmi, 0);
    cycle();
    com_rd = 1'b1; cycle(); com_rd = 1'b0;
    cycle();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_latch"}, comlatch, 0);
    chk({name, "_nmi"},   cpu_nmi,  0);
    chk({name, "_irq"},   cpu_irq,  0);
    chk({name, "_cnt"},   fifo_cnt, 0);
    chk({name, "_ovf"},   cmd_ovf,  0);
    chk({name, "_ovr"},   irq_ovr,  0);
  endtask

  initial begin
    reset_n = 1'b0; sndno = 8'h00; sndstart = 1'b0; com_rd = 1'b0;
    cpu_nmia = 1'b0; cpu_irqa = 1'b0; tick_en = 1'b0; ovf_clr = 1'b0;
    model_reset();
    #2;
    chk_all_zero("reset");
    repeat (2) cycle();
    reset_n = 1'b1;
    cycle();

    // Single request: offered two edges after the strobe rises
    push(8'h23);
    chk("t1_latch", comlatch, 8'h23);
    chk("t1_nmi", cpu_nmi, 1);
    chk("t1_cnt", fifo_cnt, 0);
    serve(8'h23);
    chk("t1_idle_nmi", cpu_nmi, 0);

    // Three queued requests served in order
    push(8'h11); push(8'h22); push(8'h33);
    chk("t2_cnt", fifo_cnt, 2);
    serve(8'h11); serve(8'h22); serve(8'h33);
    chk("t2_empty", fifo_cnt, 0);
    chk("t2_last_latch", comlatch, 8'h33);

    // Overflow: one in PEND, four queued, fifth dropped
    push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    chk("t3_full", fifo_cnt, 4);
    chk("t3_no_ovf", cmd_ovf, 0);
    push(8'h55);
    chk("t3_ovf", cmd_ovf, 1);
    chk("t3_cnt", fifo_cnt, 4);
    ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0;
    chk("t3_ovf_clr", cmd_ovf, 0);

    // Push on the same edge as a pop from a full FIFO is accepted
    cpu_nmia = 1'b1; cycle(); cpu_nmia = 1'b0;
    com_rd = 1'b1; cycle(); com_rd = 1'b0;
    chk("t5_pre_cnt", fifo_cnt, 4);
    sndno = 8'h66; sndstart = 1'b1; cycle();
    chk("t5_cnt", fifo_cnt, 4);
    chk("t5_ovf", cmd_ovf, 0);
    chk("t5_latch", comlatch, 8'hA1);
    sndstart = 1'b0; cycle();
    serve(8'hA1); serve(8'hA2); serve(8'hA3); serve(8'hA4); serve(8'h66);
    chk("t5_drained", fifo_cnt, 0);

    // Periodic IRQ, overrun and tick-beats-ack
    tick_en = 1'b1;
    repeat (P - 1) cycle();
    chk("t4_irq_early", cpu_irq, 0);
    cycle();
    chk("t4_irq_first", cpu_irq, 1);
    repeat (P) cycle();
    chk("t4_ovr", irq_ovr, 1);
    repeat (P - 1) cycle();
    cpu_irqa = 1'b1; cycle();
    chk("t4_ack_on_tick", cpu_irq, 1);
    cycle(); cpu_irqa = 1'b0;
    chk("t4_acked", cpu_irq, 0);
    ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0;
    chk("t4_ovr_clr", irq_ovr, 0);

    // Asynchronous reset while PEND with two queued and IRQ high
    push(8'hB1); push(8'hB2); push(8'hB3);
    for (int i = 0; i < 12; i++) if (!m_irq) cycle();
    chk("t6_pre_cnt", fifo_cnt, 2);
    chk("t6_pre_nmi", cpu_nmi, 1);
    chk("t6_pre_irq", cpu_irq, 1);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk_all_zero("t6_async");
    tick_en = 1'b0;
    repeat (2) cycle();
    reset_n = 1'b1;
    repeat (5) cycle();
    chk("t6_no_nmi", cpu_nmi, 0);
    push(8'hC7);
    chk("t6_new_latch", comlatch, 8'hC7);
    chk("t6_new_nmi", cpu_nmi, 1);
    repeat (2) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
